wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameters: NUM_REQ, default 3, number of write-back requesters; REG_FILE_ADDR_LEN, default 5, register address width.
REQ-002 Port clk  input  1  clock; all state updates on the rising edge.
REQ-003 Port rst  input  1  reset; asynchronous and active-low.
REQ-004 Port req_valid  input  NUM_REQ  requester i has a write pending.
REQ-005 Port req_dest  input  NUM_REQ x REG_FILE_ADDR_LEN  destination register of requester i.
REQ-006 Port req_data  input  NUM_REQ x WORD_SIZE  write value of requester i.
REQ-007 Port req_ready  output  NUM_REQ  one-hot grant; requester i's write is accepted this cycle.
REQ-008 Port wb_hold  input  1  hazard-unit pause; no grant while high.
REQ-009 Port flush  input  1  discards the registered write not yet committed.
REQ-010 Port write_en  output  1  register-file write enable.
REQ-011 Port dest  output  REG_FILE_ADDR_LEN  register-file destination address.
REQ-012 Port write_val  output  WORD_SIZE  register-file write data.
REQ-013 Port busy  output  1  write_en is high or any req_valid is high.

Function
REQ-014 A transfer on requester i SHALL occur when req_valid[i] and req_ready[i] are both high at a rising edge.
REQ-015 req_ready SHALL be combinational, SHALL have at most one bit set, and SHALL be all-zero when wb_hold is high or rst is low.
REQ-016 A requester holding req_valid high SHALL keep req_dest and req_data stable until its transfer occurs.
REQ-017 On a transfer, write_en, dest and write_val SHALL be registered, so they are valid exactly one cycle after the grant edge and stable through the following falling edge, where the register file commits.
REQ-018 With no transfer in a cycle, write_en SHALL be 0 on the next cycle; dest and write_val SHALL hold their previous values.
REQ-019 A transfer with req_dest == 0 SHALL be accepted (req_ready high) but SHALL leave write_en at 0, so register 0 is never written.
REQ-020 When flush is high at an edge, write_en SHALL be 0 on the next cycle and no grant SHALL issue in that cycle.
REQ-021 flush SHALL take precedence over wb_hold, and wb_hold SHALL take precedence over any request.
REQ-022 The arbiter SHALL keep a priority pointer ptr of width clog2(NUM_REQ).
REQ-023 The grant SHALL go to the first valid requester found scanning from ptr upward with wrap-around modulo NUM_REQ.
REQ-024 After a transfer by requester g, ptr SHALL become (g+1) mod NUM_REQ; otherwise ptr SHALL hold its value.
REQ-025 Two requesters with the same req_dest in the same cycle SHALL be served in grant order; the later grant overwrites the earlier one.
REQ-026 With every requester continuously valid, each requester SHALL be granted once in every NUM_REQ cycles.

Reset
REQ-027 While rst is low: write_en=0, dest=0, write_val=0, ptr=0, req_ready=0, and busy follows REQ-013.
REQ-028 Asserting rst mid-operation SHALL drop any registered write, so no register-file write follows the reset edge.
REQ-029 The first grant after rst deasserts SHALL be evaluated from ptr=0.

Configuration
REQ-030 Macro WB_RR_ARB_EN SHALL select the arbitration policy.
REQ-031 With WB_RR_ARB_EN defined, arbitration SHALL be round-robin as in REQ-022..REQ-026.
REQ-032 Without WB_RR_ARB_EN, ptr SHALL not exist and arbitration SHALL be fixed priority, with index 0 highest; REQ-026 does not apply.

Structure
REQ-033 WORD_SIZE SHALL come from the shared defines file.
REQ-034 The shared package SHALL hold the requester index constants: WB_REQ_ALU=0, WB_REQ_MEM=1, WB_REQ_MDU=2.
REQ-035 The package SHALL also define a typedef wb_req_t bundling {valid, dest, data}.
REQ-036 A single sub-module, wb_rr_picker, SHALL implement the combinational one-hot pick from (valid vector, ptr).

Verification
REQ-037 rst low, then high; req_valid=3'b001, dest=5, data=32'hA5 -> req_ready=3'b001 that cycle; next cycle write_en=1, dest=5, write_val=32'hA5.
REQ-038 All three valid for 6 cycles with distinct dests (round-robin build) -> grants in order 0,1,2,0,1,2; write_en high for 6 consecutive cycles starting one cycle after the first grant.
REQ-039 req_valid=3'b010, dest=0, data=32'hFFFF_FFFF -> req_ready[1]=1; write_en stays 0; register 0 reads 0.
REQ-040 req_valid=3'b100 with wb_hold=1 for 3 cycles -> req_ready=0 throughout; on the first cycle after wb_hold falls, the grant goes to requester 2.
REQ-041 Grant requester 1 (dest=7), then assert flush on the next edge -> write_en=0 on the following cycle; register 7 unchanged.
REQ-042 rst pulsed low during back-to-back grants -> write_en drops immediately; the first post-reset grant goes to the lowest valid index.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared write-back definitions.
// Holds the register-file word size, the requester index assignments, the
// requester bundle type and a helper for sizing the priority pointer.
package wb_arbiter_pkg;

  // Register-file word width shared by every write-back source.
  localparam int unsigned WORD_SIZE = 32;

  // Default register address width, used by the bundled requester type.
  localparam int unsigned WB_DEST_LEN = 5;

  // Requester slot assignments on the arbiter's request vector.
  localparam int unsigned WB_REQ_ALU = 0;
  localparam int unsigned WB_REQ_MEM = 1;
  localparam int unsigned WB_REQ_MDU = 2;

  typedef struct packed {
    logic                   valid;
    logic [WB_DEST_LEN-1:0] dest;
    logic [WORD_SIZE-1:0]   data;
  } wb_req_t;

  // Pointer/index width; a single requester still needs a 1-bit index.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational one-hot picker.
// Scans the valid vector starting at ptr and wrapping modulo NUM_REQ; the
// first valid requester found wins.
// Ports:
//   valid - request vector
//   ptr   - index that is examined first
//   grant - one-hot winner (all-zero when nothing is valid)
//   idx   - binary index of the winner (0 when nothing is valid)
//   any   - at least one requester is valid
module wb_rr_picker
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned PTR_W   = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    logic             found;
    logic [PTR_W-1:0] cand;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = PTR_W'((32'(ptr) + off) % NUM_REQ);
      if (!found && valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
    any = found;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: grants one of NUM_REQ requesters per cycle access to the
// single register-file write port and registers the winning write.
// Build option: define WB_RR_ARB_EN for round-robin arbitration; otherwise
// fixed priority with requester 0 highest and no priority pointer.
// Ports:
//   clk, rst           - clock (rising edge), asynchronous active-low reset
//   req_valid/dest/data - per-requester pending write
//   req_ready          - combinational one-hot grant
//   wb_hold            - pause: no grant while high
//   flush              - kills the presented write and blocks granting
//   write_en/dest/write_val - registered register-file write
//   busy               - write presented or any request pending
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ           = 3,
  parameter int unsigned REG_FILE_ADDR_LEN = 5
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [NUM_REQ-1:0]                          req_valid,
  input  logic [NUM_REQ-1:0][REG_FILE_ADDR_LEN-1:0]   req_dest,
  input  logic [NUM_REQ-1:0][WORD_SIZE-1:0]           req_data,
  output logic [NUM_REQ-1:0]                          req_ready,
  input  logic                                        wb_hold,
  input  logic                                        flush,
  output logic                                        write_en,
  output logic [REG_FILE_ADDR_LEN-1:0]                dest,
  output logic [WORD_SIZE-1:0]                        write_val,
  output logic                                        busy
);

  localparam int unsigned PTR_W = ptr_width(NUM_REQ);

  logic [PTR_W-1:0]             pick_ptr;
  logic [NUM_REQ-1:0]           pick_grant;
  logic [PTR_W-1:0]             grant_idx;
  logic                         pick_any;
  logic                         grant_ok;
  logic                         transfer;

  logic                         write_en_q, write_en_d;
  logic [REG_FILE_ADDR_LEN-1:0] dest_q, dest_d;
  logic [WORD_SIZE-1:0]         val_q, val_d;

`ifdef WB_RR_ARB_EN
  logic [PTR_W-1:0]             ptr_q, ptr_d;
  assign pick_ptr = ptr_q;
`else
  assign pick_ptr = '0;
`endif

  wb_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .valid (req_valid),
    .ptr   (pick_ptr),
    .grant (pick_grant),
    .idx   (grant_idx),
    .any   (pick_any)
  );

  // flush outranks wb_hold, which outranks any request; reset also blocks.
  assign grant_ok  = rst && !flush && !wb_hold;
  assign req_ready = grant_ok ? pick_grant : '0;
  assign transfer  = grant_ok && pick_any;

  always_comb begin
    write_en_d = 1'b0;
    dest_d     = dest_q;
    val_d      = val_q;
    if (transfer) begin
      // Writes to register 0 are accepted but never enabled.
      write_en_d = |req_dest[grant_idx];
      dest_d     = req_dest[grant_idx];
      val_d      = req_data[grant_idx];
    end
  end

`ifdef WB_RR_ARB_EN
  always_comb begin
    ptr_d = ptr_q;
    if (transfer) begin
      ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_en_q <= 1'b0;
      dest_q     <= '0;
      val_q      <= '0;
    end else begin
      write_en_q <= write_en_d;
      dest_q     <= dest_d;
      val_q      <= val_d;
    end
  end

  // A flush arriving while a write is presented discards it before the
  // falling-edge commit in the register file.
  assign write_en  = write_en_q && !flush;
  assign dest      = dest_q;
  assign write_val = val_q;
  assign busy      = write_en || (|req_valid);

endmodule
